ir_queue: RTL

Parametrised instruction register with a prefetch queue, replacing the single 8-bit IR in the SAP-1 datapath. Instruction words are pushed from the shared bus into a FIFO of depth DEPTH and popped into a current-instruction register on request. The current instruction is split into opcode and operand fields for the controller and the operand path. Flush, bypass and sticky overflow behaviour give the controller deterministic handling of branches and bus stalls.

---
 rtl/ir_queue.sv | 75 +++++++
 1 files changed

// File: rtl/ir_queue.sv
// Instruction register fed by a small prefetch FIFO. It supports bypass when the queue is empty,
// flush for branches, and a sticky overflow flag for dropped pushes.
module ir_queue #(
  parameter int WIDTH    = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [WIDTH-1:0]             bus,
  input  logic                         next,
  input  logic                         flush,
  output logic [WIDTH-1:0]             instruction,
  output logic [OPCODE_W-1:0]          opcode,
  output logic [WIDTH-OPCODE_W-1:0]    operand,
  output logic                         valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop, do_push, bypass, drop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign opcode  = instruction[WIDTH-1 -: OPCODE_W];
  assign operand = instruction[WIDTH-OPCODE_W-1:0];

  // A pop frees a slot, so a push alongside a pop is accepted even when full.
  always_comb begin
    do_pop  = next && !empty;
    bypass  = next && load && empty;
    do_push = load && (next ? !empty : !full);
    drop    = load && !next && full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
      instruction <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
      if (do_pop)      instruction <= mem[rd_ptr];
      else if (bypass) instruction <= bus;
      if (next) valid <= do_pop || bypass;
    end
  end

  // Storage carries no reset; its contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= bus;
  end

endmodule
